// File: rtl/snake_pkg.sv
// Shared types and constants for the seed exchange link stage.
package snake_pkg;

    // Transmit-side state: send the two seed bytes, then wait for the peer's ACK.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_X   = 3'd1,
        SEND_Y   = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4,
        FAIL     = 3'd5
    } seed_tx_state_e;

    // Receive-side parser state: expecting the X byte or the Y byte of a packet.
    typedef enum logic {
        WAIT_X = 1'b0,
        WAIT_Y = 1'b1
    } seed_rx_state_e;

    localparam logic [2:0] SEED_TAG_X = 3'b101;
    localparam logic [2:0] SEED_TAG_Y = 3'b110;
    localparam logic [7:0] SEED_ACK   = 8'hAC;

    // Builds one packet byte from a 3-bit tag and a 5-bit seed field.
    function automatic logic [7:0] seed_byte(input logic [2:0] tag, input logic [4:0] value);
        return {tag, value};
    endfunction

endpackage

// File: rtl/seed_rx_parser.sv
// Parses the peer's 2-byte seed packets and holds the latest remote seeds.
// The ACK byte shares the X tag bits, so it is filtered out before tag decoding.
module seed_rx_parser
    import snake_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 75_000_000,
    parameter logic [7:0]  ACK_BYTE       = SEED_ACK
) (
    input  logic       clk_75,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [4:0] seed_x_in,
    output logic [4:0] seed_y_in,
    output logic       remote_valid,
    output logic       pkt_done,
    output logic       ack_seen
);

    localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    seed_rx_state_e state_reg, state_next;
    logic [TW-1:0]  gap_reg, gap_next;
    logic [4:0]     temp_x_reg, temp_x_next;
    logic [4:0]     seed_x_reg, seed_x_next;
    logic [4:0]     seed_y_reg, seed_y_next;
    logic           remote_valid_reg, remote_valid_next;

    logic is_ack_byte;
    logic is_x_byte;
    logic is_y_byte;
    logic is_other_byte;

    assign is_ack_byte   = rx_valid && (rx_data == ACK_BYTE);
    assign is_x_byte     = rx_valid && !is_ack_byte && (rx_data[7:5] == SEED_TAG_X);
    assign is_y_byte     = rx_valid && !is_ack_byte && (rx_data[7:5] == SEED_TAG_Y);
    assign is_other_byte = rx_valid && !is_ack_byte && !is_x_byte && !is_y_byte;

    assign ack_seen     = is_ack_byte;
    assign seed_x_in    = seed_x_reg;
    assign seed_y_in    = seed_y_reg;
    assign remote_valid = remote_valid_reg;

    // Parser state, gap timer and remote seed registers.
    always_ff @(posedge clk_75 or posedge rst) begin
        if (rst) begin
            state_reg        <= WAIT_X;
            gap_reg          <= '0;
            temp_x_reg       <= '0;
            seed_x_reg       <= '0;
            seed_y_reg       <= '0;
            remote_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            gap_reg          <= gap_next;
            temp_x_reg       <= temp_x_next;
            seed_x_reg       <= seed_x_next;
            seed_y_reg       <= seed_y_next;
            remote_valid_reg <= remote_valid_next;
        end
    end

    // Next-state logic: an X byte always (re)starts a packet, a Y byte completes it.
    always_comb begin
        state_next        = state_reg;
        gap_next          = gap_reg;
        temp_x_next       = temp_x_reg;
        seed_x_next       = seed_x_reg;
        seed_y_next       = seed_y_reg;
        remote_valid_next = remote_valid_reg;
        pkt_done          = 1'b0;
        case (state_reg)
            WAIT_X: begin
                if (is_x_byte) begin
                    temp_x_next = rx_data[4:0];
                    gap_next    = TW'(TIMEOUT_CYCLES);
                    state_next  = WAIT_Y;
                end
            end
            WAIT_Y: begin
                if (is_x_byte) begin
                    temp_x_next = rx_data[4:0];
                    gap_next    = TW'(TIMEOUT_CYCLES);
                end else if (is_y_byte) begin
                    seed_x_next       = temp_x_reg;
                    seed_y_next       = rx_data[4:0];
                    remote_valid_next = 1'b1;
                    pkt_done          = 1'b1;
                    state_next        = WAIT_X;
                end else if (is_other_byte) begin
                    state_next = WAIT_X;
                end else if (gap_reg <= TW'(1)) begin
                    gap_next   = '0;
                    state_next = WAIT_X;
                end else begin
                    gap_next = gap_reg - TW'(1);
                end
            end
            default: begin
                state_next = WAIT_X;
            end
        endcase
    end

endmodule

// File: rtl/seed_exchange.sv
// Link stage: sends local seeds as a tagged packet with ACK/retry, and ACKs
// packets received from the peer. Seed bytes take priority over a pending ACK
// so an ACK is never placed between byte0 and byte1.
module seed_exchange
    import snake_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 75_000_000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter logic [7:0]  ACK_BYTE       = SEED_ACK
) (
    input  logic       clk_75,
    input  logic       rst,
    input  logic [4:0] seed_x,
    input  logic [4:0] seed_y,
    input  logic       seed_rdy,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [4:0] seed_x_in,
    output logic [4:0] seed_y_in,
    output logic       remote_valid,
    output logic       link_ok,
    output logic       link_err
);

    localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    seed_tx_state_e state_reg, state_next;
    logic           seed_rdy_prev_reg;
    logic [4:0]     lat_x_reg, lat_x_next;
    logic [4:0]     lat_y_reg, lat_y_next;
    logic [RW-1:0]  retry_reg, retry_next;
    logic [TW-1:0]  timer_reg, timer_next;
    logic           ack_pending_reg, ack_pending_next;
    logic           start_wait_reg, start_wait_next;

    logic pkt_done;
    logic ack_seen;
    logic rdy_rise;
    logic seed_send;
    logic ack_send;
    logic ack_hs;

    seed_rx_parser #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .ACK_BYTE       (ACK_BYTE)
    ) u_rx_parser (
        .clk_75       (clk_75),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .seed_x_in    (seed_x_in),
        .seed_y_in    (seed_y_in),
        .remote_valid (remote_valid),
        .pkt_done     (pkt_done),
        .ack_seen     (ack_seen)
    );

    assign rdy_rise  = seed_rdy && !seed_rdy_prev_reg;
    assign seed_send = (state_reg == SEND_X) || (state_reg == SEND_Y);
    assign ack_send  = ack_pending_reg && !seed_send;
    assign ack_hs    = ack_send && tx_ready;

    assign link_ok  = (state_reg == DONE);
    assign link_err = (state_reg == FAIL);

    // Byte mux towards the UART: seed bytes in the send states, otherwise a pending ACK.
    always_comb begin
        tx_valid = seed_send || ack_send;
        tx_data  = 8'h00;
        if (state_reg == SEND_X) begin
            tx_data = seed_byte(SEED_TAG_X, lat_x_reg);
        end else if (state_reg == SEND_Y) begin
            tx_data = seed_byte(SEED_TAG_Y, lat_y_reg);
        end else if (ack_send) begin
            tx_data = ACK_BYTE;
        end
    end

    // Edge-detect register; it resets high so a seed_rdy already high at reset
    // release is not mistaken for a new request.
    always_ff @(posedge clk_75 or posedge rst) begin
        if (rst) begin
            seed_rdy_prev_reg <= 1'b1;
        end else begin
            seed_rdy_prev_reg <= seed_rdy;
        end
    end

    // TX state, latched seeds, retry/timeout counters and ACK bookkeeping.
    always_ff @(posedge clk_75 or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            lat_x_reg       <= '0;
            lat_y_reg       <= '0;
            retry_reg       <= '0;
            timer_reg       <= '0;
            ack_pending_reg <= 1'b0;
            start_wait_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            lat_x_reg       <= lat_x_next;
            lat_y_reg       <= lat_y_next;
            retry_reg       <= retry_next;
            timer_reg       <= timer_next;
            ack_pending_reg <= ack_pending_next;
            start_wait_reg  <= start_wait_next;
        end
    end

    // ACK bookkeeping: a newly completed packet wins over a simultaneous ACK handshake.
    always_comb begin
        ack_pending_next = ack_pending_reg;
        if (pkt_done) begin
            ack_pending_next = 1'b1;
        end else if (ack_hs) begin
            ack_pending_next = 1'b0;
        end
    end

    // TX next-state logic; dropping seed_rdy aborts any transfer in progress.
    always_comb begin
        state_next      = state_reg;
        lat_x_next      = lat_x_reg;
        lat_y_next      = lat_y_reg;
        retry_next      = retry_reg;
        timer_next      = timer_reg;
        start_wait_next = start_wait_reg;
        case (state_reg)
            IDLE: begin
                if (!seed_rdy) begin
                    start_wait_next = 1'b0;
                end else if (rdy_rise || start_wait_reg) begin
                    if (rdy_rise) begin
                        lat_x_next = seed_x;
                        lat_y_next = seed_y;
                    end
                    // A pending ACK goes out first; the request is held meanwhile.
                    if (ack_pending_reg && !tx_ready) begin
                        start_wait_next = 1'b1;
                    end else begin
                        start_wait_next = 1'b0;
                        retry_next      = '0;
                        state_next      = SEND_X;
                    end
                end
            end
            SEND_X: begin
                if (!seed_rdy) begin
                    state_next = IDLE;
                end else if (tx_ready) begin
                    state_next = SEND_Y;
                end
            end
            SEND_Y: begin
                if (!seed_rdy) begin
                    state_next = IDLE;
                end else if (tx_ready) begin
                    timer_next = TW'(TIMEOUT_CYCLES);
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (timer_reg != '0) begin
                    timer_next = timer_reg - TW'(1);
                end
                if (!seed_rdy) begin
                    state_next = IDLE;
                end else if (ack_seen) begin
                    state_next = DONE;
                end else if (timer_reg <= TW'(1)) begin
                    if (retry_reg < RW'(MAX_RETRIES)) begin
                        retry_next = retry_reg + RW'(1);
                        state_next = SEND_X;
                    end else begin
                        state_next = FAIL;
                    end
                end
            end
            DONE, FAIL: begin
                if (!seed_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seed_exchange.sv
// Directed bench for seed_exchange with a short timeout and two retries.
module tb_seed_exchange;

    logic       clk_75;
    logic       rst;
    logic [4:0] seed_x;
    logic [4:0] seed_y;
    logic       seed_rdy;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] seed_x_in;
    logic [4:0] seed_y_in;
    logic       remote_valid;
    logic       link_ok;
    logic       link_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] tx_bytes[$];
    int         tx_times[$];

    seed_exchange #(
        .TIMEOUT_CYCLES (20),
        .MAX_RETRIES    (2),
        .ACK_BYTE       (8'hAC)
    ) dut (
        .clk_75       (clk_75),
        .rst          (rst),
        .seed_x       (seed_x),
        .seed_y       (seed_y),
        .seed_rdy     (seed_rdy),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .seed_x_in    (seed_x_in),
        .seed_y_in    (seed_y_in),
        .remote_valid (remote_valid),
        .link_ok      (link_ok),
        .link_err     (link_err)
    );

    initial clk_75 = 1'b0;
    always #5 clk_75 = ~clk_75;

    // Inputs change just after posedge, so the negedge sees a stable handshake.
    always @(negedge clk_75) begin
        cyc = cyc + 1;
        if (tx_valid && tx_ready) begin
            tx_bytes.push_back(tx_data);
            tx_times.push_back(cyc);
            $display("tx byte %0d: data=%02h at cycle %0d", tx_bytes.size() - 1, tx_data, cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_75);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (tx_bytes.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        // Let the handshake edge of the last captured byte pass.
        tick(1);
        check(tag, 32'(tx_bytes.size() >= n), 32'd1);
    endtask

    function automatic logic [31:0] byte_at(input int i);
        if (i < tx_bytes.size()) return 32'(tx_bytes[i]);
        return 32'hDEAD;
    endfunction

    function automatic int time_at(input int i);
        if (i < tx_times.size()) return tx_times[i];
        return -1;
    endfunction

    task automatic clear_log();
        tx_bytes.delete();
        tx_times.delete();
    endtask

    initial begin
        rst      = 1'b1;
        seed_x   = 5'd0;
        seed_y   = 5'd0;
        seed_rdy = 1'b0;
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tick(2);

        // Reset state.
        check("reset_tx_valid", 32'(tx_valid), 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'h00);
        check("reset_link_ok", 32'(link_ok), 32'd0);
        check("reset_link_err", 32'(link_err), 32'd0);
        check("reset_remote_valid", 32'(remote_valid), 32'd0);
        rst = 1'b0;
        tick(2);

        // Send and ACK: x=7 -> A7, y=12 -> CC; later seed changes are ignored.
        tx_ready = 1'b1;
        seed_x   = 5'd7;
        seed_y   = 5'd12;
        seed_rdy = 1'b1;
        tick(1);
        seed_x = 5'd31;
        seed_y = 5'd0;
        wait_bytes("send_two_bytes", 2, 10);
        check("send_byte0", byte_at(0), 32'hA7);
        check("send_byte1", byte_at(1), 32'hCC);
        send_rx(8'hAC);
        check("ack_link_ok", 32'(link_ok), 32'd1);
        check("ack_tx_valid", 32'(tx_valid), 32'd0);
        check("ack_not_seed", 32'(remote_valid), 32'd0);
        seed_rdy = 1'b0;
        tick(1);
        check("ack_link_ok_clear", 32'(link_ok), 32'd0);
        check("ack_no_extra_bytes", 32'(tx_bytes.size()), 32'd2);

        // Retry and fail: 3 sends, each byte0 21 edges after the previous byte1.
        clear_log();
        seed_x   = 5'd1;
        seed_y   = 5'd2;
        seed_rdy = 1'b1;
        wait_bytes("retry_six_bytes", 6, 200);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("retry_byte0_%0d", i), byte_at(2 * i), 32'hA1);
            check($sformatf("retry_byte1_%0d", i), byte_at(2 * i + 1), 32'hC2);
        end
        check("retry_gap_1", 32'(time_at(2) - time_at(1)), 32'd21);
        check("retry_gap_2", 32'(time_at(4) - time_at(3)), 32'd21);
        tick(18);
        check("fail_not_yet", 32'(link_err), 32'd0);
        tick(1);
        check("fail_link_err", 32'(link_err), 32'd1);
        check("fail_no_fourth_send", 32'(tx_bytes.size()), 32'd6);
        seed_rdy = 1'b0;
        tick(1);
        check("fail_link_err_clear", 32'(link_err), 32'd0);
        check("fail_idle_tx_valid", 32'(tx_valid), 32'd0);

        // RX packet A3, D5 -> x=3, y=21 and exactly one ACK.
        clear_log();
        send_rx(8'hA3);
        send_rx(8'hD5);
        check("rx_seed_x", 32'(seed_x_in), 32'd3);
        check("rx_seed_y", 32'(seed_y_in), 32'd21);
        check("rx_remote_valid", 32'(remote_valid), 32'd1);
        tick(3);
        check("rx_ack_count", 32'(tx_bytes.size()), 32'd1);
        check("rx_ack_byte", byte_at(0), 32'hAC);
        check("rx_ack_done", 32'(tx_valid), 32'd0);

        // RX errors: bad second byte.
        clear_log();
        send_rx(8'hA3);
        send_rx(8'h00);
        tick(3);
        check("rxerr_bad_y_x", 32'(seed_x_in), 32'd3);
        check("rxerr_bad_y_y", 32'(seed_y_in), 32'd21);
        check("rxerr_bad_y_no_ack", 32'(tx_bytes.size()), 32'd0);

        // RX errors: repeated X restarts the packet.
        send_rx(8'hA3);
        send_rx(8'hA4);
        send_rx(8'hC2);
        check("rxerr_restart_x", 32'(seed_x_in), 32'd4);
        check("rxerr_restart_y", 32'(seed_y_in), 32'd2);
        tick(3);
        check("rxerr_restart_ack", byte_at(0), 32'hAC);

        // RX errors: gap beyond the timeout discards the packet.
        clear_log();
        send_rx(8'hA3);
        tick(25);
        send_rx(8'hC2);
        tick(3);
        check("rxerr_gap_x", 32'(seed_x_in), 32'd4);
        check("rxerr_gap_y", 32'(seed_y_in), 32'd2);
        check("rxerr_gap_no_ack", 32'(tx_bytes.size()), 32'd0);

        // Longest accepted gap: Y arrives on the 20th cycle after X.
        send_rx(8'hA5);
        tick(19);
        send_rx(8'hC7);
        check("rx_gap_edge_x", 32'(seed_x_in), 32'd5);
        check("rx_gap_edge_y", 32'(seed_y_in), 32'd7);
        tick(3);

        // Collision: packet completes while SEND_X is stalled; ACK follows byte1.
        clear_log();
        seed_x   = 5'd9;
        seed_y   = 5'd3;
        tx_ready = 1'b0;
        seed_rdy = 1'b1;
        tick(1);
        send_rx(8'hA3);
        send_rx(8'hD5);
        tick(3);
        tx_ready = 1'b1;
        wait_bytes("coll_three_bytes", 3, 20);
        check("coll_byte0", byte_at(0), 32'hA9);
        check("coll_byte1", byte_at(1), 32'hC3);
        check("coll_byte2", byte_at(2), 32'hAC);
        seed_rdy = 1'b0;
        tick(2);

        // Reset in the middle of SEND_Y.
        clear_log();
        seed_x   = 5'd2;
        seed_y   = 5'd5;
        seed_rdy = 1'b1;
        tick(2);
        tx_ready = 1'b0;
        tick(1);
        check("rst_in_send_y_valid", 32'(tx_valid), 32'd1);
        check("rst_in_send_y_data", 32'(tx_data), 32'hC5);
        #2 rst = 1'b1;
        #1;
        check("rst_async_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_async_tx_data", 32'(tx_data), 32'h00);
        check("rst_async_remote", 32'(remote_valid), 32'd0);
        check("rst_async_seed_x_in", 32'(seed_x_in), 32'd0);
        check("rst_async_link", 32'({link_ok, link_err}), 32'd0);
        tick(1);
        #2 rst = 1'b0;
        clear_log();
        tx_ready = 1'b1;
        tick(6);
        check("rst_no_send_level", 32'(tx_bytes.size()), 32'd0);
        seed_rdy = 1'b0;
        tick(1);
        seed_rdy = 1'b1;
        wait_bytes("rst_new_edge_send", 2, 10);
        check("rst_new_byte0", byte_at(0), 32'hA2);
        check("rst_new_byte1", byte_at(1), 32'hC5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seed_exchange.md
Name: seed_exchange

Overview:
- UART-side link stage between the point generator and the byte-level UART TX/RX.
- On `seed_rdy` it sends the local 5-bit seeds to the peer board as a tagged 2-byte packet, waits for an ACK byte and retransmits on timeout.
- In parallel it parses the peer's packets, presents the remote seeds as `seed_x_in`/`seed_y_in` to the point generator, and answers each valid packet with an ACK.

Parameters:
- `TIMEOUT_CYCLES`, 75_000_000, clk_75 cycles to wait for an ACK, and maximum gap between RX packet bytes.
- `MAX_RETRIES`, 3, retransmissions after the first send before declaring failure.
- `ACK_BYTE`, 8'hAC, acknowledge byte value.

Ports:
- `clk_75` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `seed_x` input 5: local X seed.
- `seed_y` input 5: local Y seed.
- `seed_rdy` input 1: level; 0->1 requests a send; falling aborts.
- `tx_data` output 8: byte to UART TX.
- `tx_valid` output 1: `tx_data` valid.
- `tx_ready` input 1: UART TX accepts; a byte transfers in a cycle where `tx_valid` && `tx_ready`.
- `rx_data` input 8: received byte.
- `rx_valid` input 1: one-cycle strobe per received byte.
- `seed_x_in` output 5: latest remote X seed.
- `seed_y_in` output 5: latest remote Y seed.
- `remote_valid` output 1: sticky; a remote packet has been received since reset.
- `link_ok` output 1: local packet acknowledged.
- `link_err` output 1: retries exhausted.

Behaviour:
- Reset (async, any state):
  - All outputs 0; TX FSM = `IDLE`; RX parser = `WAIT_X`.
  - Timers, retry counter and `ack_pending` cleared.
- Packet format:
  - byte0 = {3'b101, x}; byte1 = {3'b110, y}.
  - Any other tag is not a seed byte.
- TX FSM, states `IDLE`, `SEND_X`, `SEND_Y`, `WAIT_ACK`, `DONE`, `FAIL`:
  - `IDLE`: on a `seed_rdy` rising edge (registered previous value), latch `seed_x`/`seed_y`, clear the retry count and go to `SEND_X`. Later changes to `seed_x`/`seed_y` are ignored until the next request.
  - `SEND_X`: `tx_valid`=1, `tx_data`=byte0; on handshake go to `SEND_Y`.
  - `SEND_Y`: same with byte1; on handshake load the timer with `TIMEOUT_CYCLES` and go to `WAIT_ACK`.
  - `WAIT_ACK`:
    - The timer decrements each cycle.
    - `rx_valid` with `rx_data`==`ACK_BYTE` -> `DONE`, `link_ok`=1.
    - Timer reaches 0 with retries < `MAX_RETRIES` -> retries+1, go to `SEND_X` using the latched seeds.
    - Timer reaches 0 otherwise -> `FAIL`, `link_err`=1.
    - ACK and timeout in the same cycle: ACK wins.
  - `DONE`/`FAIL`: hold until `seed_rdy`=0, then `IDLE`; `link_ok`/`link_err` clear on that transition.
  - `seed_rdy` falling in any non-`IDLE` state: go to `IDLE` next cycle, clear `link_ok`/`link_err`. A byte already handshaken is not recalled.
- ACK transmission:
  - A valid RX packet sets `ack_pending`.
  - In `IDLE`, `WAIT_ACK`, `DONE` and `FAIL` with `ack_pending`: `tx_valid`=1, `tx_data`=`ACK_BYTE`; the handshake clears `ack_pending`.
  - An ACK is never inserted between byte0 and byte1.
  - A `seed_rdy` rise while an ACK is pending waits until the ACK is sent.
  - A second packet while `ack_pending` is set still yields only one ACK.
  - The `WAIT_ACK` timer keeps running while the ACK is sent.
- RX parser, states `WAIT_X`, `WAIT_Y`:
  - `WAIT_X`: byte with tag 101 -> hold x in a temp, load the gap timer, go to `WAIT_Y`.
  - `WAIT_Y`:
    - Tag 110 -> `seed_x_in`<=temp, `seed_y_in`<=y (same cycle), `remote_valid`<=1, set `ack_pending`, go to `WAIT_X`.
    - Tag 101 -> restart with the new x.
    - Any other byte, or gap timer expiry -> discard, go to `WAIT_X`.
  - `ACK_BYTE` is not a seed tag; it is consumed by TX only in `WAIT_ACK` and is ignored by the parser.
  - The parser runs independently of the TX FSM and of `seed_rdy`.
- Widths:
  - Timers are $clog2(`TIMEOUT_CYCLES`+1) bits.
  - Retry counter is $clog2(`MAX_RETRIES`+1) bits.
  - `seed_x_in`/`seed_y_in` update only on a complete packet; the 5-bit fields are passed through with no modulo.

Decomposition:
- `snake_pkg` gets:
  - `seed_tx_state_e` and `seed_rx_state_e` enums;
  - constants `SEED_TAG_X`=3'b101, `SEED_TAG_Y`=3'b110, `SEED_ACK`=8'hAC.
- One sub-module, `seed_rx_parser` (RX FSM, gap timer, remote seed registers). It outputs `pkt_done` (which sets `ack_pending`) and `ack_seen`.
- TX FSM, ACK arbitration and the retry timer stay in `seed_exchange`.

Test Plan:
- Send and ACK: `seed_x`=5'd7, `seed_y`=5'd12, raise `seed_rdy`, `tx_ready`=1 -> `tx_data` 8'hA7 then 8'hCC; inject 8'hAC -> `link_ok`=1, `tx_valid`=0.
- Retry and fail: `TIMEOUT_CYCLES`=20, `MAX_RETRIES`=2, no ACK -> packet sent 3 times, each send 20 cycles after the previous byte1; `link_err`=1 after the third timeout; `seed_rdy`=0 -> `IDLE`, `link_err`=0.
- RX packet: inject 8'hA3, 8'hD5 -> `seed_x_in`=3, `seed_y_in`=21, `remote_valid`=1; one 8'hAC byte transmitted.
- RX errors:
  - 8'hA3, 8'h00 -> no update;
  - 8'hA3, 8'hA4, 8'hC2 -> `seed_x_in`=4, `seed_y_in`=2;
  - 8'hA3, then gap > `TIMEOUT_CYCLES`, then 8'hC2 -> no update.
- Collision: RX packet completes while TX is in `SEND_X` with `tx_ready` held low 5 cycles -> bytes observed in order A-byte, C-byte, 8'hAC.
- Reset mid-`SEND_Y`: assert `rst` asynchronously -> `tx_valid`=0, all outputs 0 in the same cycle; after release, the TX FSM is in `IDLE` with `seed_rdy` high, and a send starts only on a new 0->1 edge.
